id_ex_ctrl_pipe: RTL and testbench
==================================

// Module: id_ex_ctrl_pipe
// PURPOSE
//  Second-generation decode/control stage for the pipelined MIPS core: decodes the IF/ID instruction and registers the control bundle into ID/EX.
//  Adds byte/half memory ops, xor/sra/srav and the mult/div/mfhi/mflo group, plus load-use and mul/div-busy hazard stalls and redirect flushes.
//  Sits between the IF/ID register and the EX stage; the datapath holds PC and IF/ID while stall_id=1.
// PARAMETERS
//  REG_AW      5   register-address width
//  ALUOP_W     4   ALU-op field width (>=4)
//  MDU_LAT     8   cycles mult/div occupies HI/LO after issue (1..255)
//  LU_STALL_EN 1   1: detect load-use hazards in hardware; 0: the compiler schedules around them
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        synchronous, active-high reset
//  id_instr      in   32       IF/ID instruction
//  id_valid      in   1        IF/ID holds a real instruction
//  ex_redirect   in   1        EX resolved taken branch/jump; squash ID
//  stall_id      out  1        hold PC and IF/ID this cycle (combinational)
//  flush_id      out  1        clear IF/ID next edge (= ex_redirect)
//  ex_valid      out  1        ID/EX slot is a live instruction
//  ex_reg_write  out  1        write-back enable
//  ex_wreg       out  REG_AW   destination: rd (R-type, jalr), 31 (jal), rt (others)
//  ex_mem_read   out  1        load
//  ex_mem_write  out  1        store
//  ex_memto_reg  out  1        write-back from memory
//  ex_mem_size   out  2        00 byte, 01 half, 10 word
//  ex_mem_uns    out  1        zero-extend load (lbu/lhu)
//  ex_alu_src    out  1        B operand = immediate
//  ex_ext_op     out  1        1 sign-extend, 0 zero-extend imm
//  ex_alu_op     out  ALUOP_W  ALU op (see BEHAVIOUR)
//  ex_shamt_var  out  1        shift amount from rs (sllv/srlv/srav)
//  ex_shift_op   out  2        00 none, 01 sll, 10 srl, 11 sra
//  ex_br_op      out  2        00 none, 01 beq, 10 bne
//  ex_jump       out  1        j/jal/jr/jalr
//  ex_jump_reg   out  1        jr/jalr
//  ex_call       out  1        jal/jalr (link)
//  ex_mdu_op     out  3        0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo
// BEHAVIOUR
//  Reset: every ex_* output 0, MDU counter 0; stall_id=0; flush_id follows ex_redirect.
//  Latency: decode is combinational; the bundle appears on ex_* one clk after the edge that accepts it.
//  ALU op: 0000 pass/shift, 0001 add(add/addu/addi/addiu/ld/st), 0010 sub(sub/subu), 0011 and(and/andi),
//    0100 or(or/ori), 0101 slt(slt/slti), 0110 sltu(sltu/sltiu), 1000 xor(xor/xori), 1100 lui, 1110 nor.
//  ext_op=1 for addi/addiu/slti/sltiu/loads/stores/branches; 0 for andi/ori/xori/lui.
//  Bubble: ex_valid=0 with all other ex_* outputs 0.
//  Unknown opcode/funct, or id_valid=0: bubble, no stall.
//  rs_used: R-type except sll/srl/sra/mfhi/mflo; all I-type except lui; jr/jalr.
//  rt_used: R-type, beq/bne, stores.
//  Load-use (LU_STALL_EN=1): ex_valid & ex_mem_read & ex_wreg!=0 & ((rs_used & rs==ex_wreg) | (rt_used & rt==ex_wreg)).
//    Response: stall_id=1 and a bubble is loaded into ID/EX; exactly 1 cycle.
//  MDU counter: loads MDU_LAT when mult/multu/div/divu enters ID/EX, then decrements to 0 and saturates there.
//    While the counter is nonzero, any mdu op in ID raises stall_id=1 with a bubble into ID/EX.
//  Priority: rst > ex_redirect > stall > normal.
//    ex_redirect=1: ID/EX gets a bubble, flush_id=1, stall_id=0, and the MDU counter still counts.
//  Register $0 writes: reg_write is forced to 0 when the computed wreg==0.
//  rst mid-operation: clears the counter and the bundle at the next edge; no stall is pending afterwards.
// TESTING
//  add $3,$1,$2 (0x00221820) -> next cycle ex_reg_write=1, ex_wreg=3, ex_alu_op=0001, ex_alu_src=0.
//  lw $5,0($1) then add $6,$5,$2 -> stall_id=1 for 1 cycle, one bubble, then add issues.
//  lhu $4,2($1) -> ex_mem_size=01, ex_mem_uns=1, ex_ext_op=1. sb -> ex_mem_write=1, ex_mem_size=00.
//  mult, then mflo at next cycle, MDU_LAT=8 -> mflo stalled 8 cycles, then issues with ex_mdu_op=6.
//  ex_redirect=1 coincident with a load-use stall -> flush_id=1, stall_id=0, bubble in ID/EX.
//  jal 0x100 -> ex_wreg=31, ex_call=1, ex_jump=1. rst asserted mid mul-busy -> counter 0, all ex_* 0.

Source files
------------

// File: rtl/id_ex_ctrl_pipe_if.sv
// Decode-stage bus: IF/ID instruction in, hazard/flush controls and the ID/EX control bundle out.
// master drives the IF/ID side; slave is the decode/control stage.
interface id_ex_ctrl_pipe_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
);
  logic [31:0]        id_instr;
  logic               id_valid;
  logic               ex_redirect;
  logic               stall_id;
  logic               flush_id;
  logic               ex_valid;
  logic               ex_reg_write;
  logic [REG_AW-1:0]  ex_wreg;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_memto_reg;
  logic [1:0]         ex_mem_size;
  logic               ex_mem_uns;
  logic               ex_alu_src;
  logic               ex_ext_op;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_shamt_var;
  logic [1:0]         ex_shift_op;
  logic [1:0]         ex_br_op;
  logic               ex_jump;
  logic               ex_jump_reg;
  logic               ex_call;
  logic [2:0]         ex_mdu_op;

  modport master (
    output id_instr, id_valid, ex_redirect,
    input  stall_id, flush_id, ex_valid, ex_reg_write, ex_wreg, ex_mem_read, ex_mem_write,
           ex_memto_reg, ex_mem_size, ex_mem_uns, ex_alu_src, ex_ext_op, ex_alu_op,
           ex_shamt_var, ex_shift_op, ex_br_op, ex_jump, ex_jump_reg, ex_call, ex_mdu_op
  );

  modport slave (
    input  id_instr, id_valid, ex_redirect,
    output stall_id, flush_id, ex_valid, ex_reg_write, ex_wreg, ex_mem_read, ex_mem_write,
           ex_memto_reg, ex_mem_size, ex_mem_uns, ex_alu_src, ex_ext_op, ex_alu_op,
           ex_shamt_var, ex_shift_op, ex_br_op, ex_jump, ex_jump_reg, ex_call, ex_mdu_op
  );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// MIPS decode stage: decodes IF/ID and registers the control bundle into ID/EX one clk later.
// Backpressure: stall_id (combinational) holds PC and IF/ID on load-use or MDU-busy; redirect squashes ID.
module id_ex_ctrl_pipe #(
  parameter int REG_AW      = 5,
  parameter int ALUOP_W     = 4,
  parameter int MDU_LAT     = 8,
  parameter int LU_STALL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_ctrl_pipe_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] wreg;
    logic              mem_read;
    logic              mem_write;
    logic              memto_reg;
    logic [1:0]        mem_size;
    logic              mem_uns;
    logic              alu_src;
    logic              ext_op;
    logic [3:0]        alu_op;
    logic              shamt_var;
    logic [1:0]        shift_op;
    logic [1:0]        br_op;
    logic              jump;
    logic              jump_reg;
    logic              call;
    logic [2:0]        mdu_op;
  } ctrl_t;

  ctrl_t      dec, ctrl_d, ctrl_q;
  logic [7:0] mdu_cnt_d, mdu_cnt_q;
  logic       known, rs_used, rt_used;
  logic       id_live, lu_hazard, mdu_hazard, stall;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;

  assign opcode       = bus.id_instr[31:26];
  assign rs           = bus.id_instr[25:21];
  assign rt           = bus.id_instr[20:16];
  assign rd           = bus.id_instr[15:11];
  assign funct        = bus.id_instr[5:0];
  assign unused_shamt = ^bus.id_instr[10:6];

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.wreg  = REG_AW'(rt);
    known     = 1'b1;
    rs_used   = 1'b1;
    rt_used   = 1'b0;
    case (opcode)
      6'h00: begin
        rt_used       = 1'b1;
        dec.reg_write = 1'b1;
        dec.wreg      = REG_AW'(rd);
        case (funct)
          6'h00: begin dec.shift_op = 2'b01; rs_used = 1'b0; end
          6'h02: begin dec.shift_op = 2'b10; rs_used = 1'b0; end
          6'h03: begin dec.shift_op = 2'b11; rs_used = 1'b0; end
          6'h04: begin dec.shift_op = 2'b01; dec.shamt_var = 1'b1; end
          6'h06: begin dec.shift_op = 2'b10; dec.shamt_var = 1'b1; end
          6'h07: begin dec.shift_op = 2'b11; dec.shamt_var = 1'b1; end
          6'h08: begin dec.jump = 1'b1; dec.jump_reg = 1'b1; dec.reg_write = 1'b0; end
          6'h09: begin dec.jump = 1'b1; dec.jump_reg = 1'b1; dec.call = 1'b1; end
          6'h10: begin dec.mdu_op = 3'd5; rs_used = 1'b0; end
          6'h12: begin dec.mdu_op = 3'd6; rs_used = 1'b0; end
          6'h18: begin dec.mdu_op = 3'd1; dec.reg_write = 1'b0; end
          6'h19: begin dec.mdu_op = 3'd2; dec.reg_write = 1'b0; end
          6'h1a: begin dec.mdu_op = 3'd3; dec.reg_write = 1'b0; end
          6'h1b: begin dec.mdu_op = 3'd4; dec.reg_write = 1'b0; end
          6'h20, 6'h21: dec.alu_op = 4'b0001;
          6'h22, 6'h23: dec.alu_op = 4'b0010;
          6'h24:        dec.alu_op = 4'b0011;
          6'h25:        dec.alu_op = 4'b0100;
          6'h26:        dec.alu_op = 4'b1000;
          6'h27:        dec.alu_op = 4'b1110;
          6'h2a:        dec.alu_op = 4'b0101;
          6'h2b:        dec.alu_op = 4'b0110;
          default:      known = 1'b0;
        endcase
      end
      6'h02: begin dec.jump = 1'b1; rs_used = 1'b0; end
      6'h03: begin
        dec.jump = 1'b1; dec.call = 1'b1; dec.reg_write = 1'b1;
        dec.wreg = REG_AW'(5'd31); rs_used = 1'b0;
      end
      6'h04: begin dec.br_op = 2'b01; dec.ext_op = 1'b1; rt_used = 1'b1; end
      6'h05: begin dec.br_op = 2'b10; dec.ext_op = 1'b1; rt_used = 1'b1; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = (opcode <= 6'h0b);
        case (opcode[2:0])
          3'd0, 3'd1: dec.alu_op = 4'b0001;
          3'd2:       dec.alu_op = 4'b0101;
          3'd3:       dec.alu_op = 4'b0110;
          3'd4:       dec.alu_op = 4'b0011;
          3'd5:       dec.alu_op = 4'b0100;
          3'd6:       dec.alu_op = 4'b1000;
          default: begin dec.alu_op = 4'b1100; rs_used = 1'b0; end
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.memto_reg = 1'b1;
        dec.alu_src   = 1'b1; dec.ext_op   = 1'b1; dec.alu_op    = 4'b0001;
        dec.mem_size  = opcode[1:0] == 2'b11 ? 2'b10 : {1'b0, opcode[0]};
        dec.mem_uns   = opcode[2];
      end
      6'h28, 6'h29, 6'h2b: begin
        dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = 1'b1;
        dec.alu_op    = 4'b0001; rt_used = 1'b1;
        dec.mem_size  = opcode[1:0] == 2'b11 ? 2'b10 : {1'b0, opcode[0]};
      end
      default: known = 1'b0;
    endcase
    // $0 is hardwired; never let a write-back target it
    if (dec.wreg == '0) dec.reg_write = 1'b0;
  end

  always_comb begin
    id_live    = bus.id_valid & known;
    lu_hazard  = (LU_STALL_EN != 0) & id_live & ctrl_q.valid & ctrl_q.mem_read &
                 (ctrl_q.wreg != '0) &
                 ((rs_used & (REG_AW'(rs) == ctrl_q.wreg)) |
                  (rt_used & (REG_AW'(rt) == ctrl_q.wreg)));
    mdu_hazard = id_live & (dec.mdu_op != 3'd0) & (mdu_cnt_q != 8'd0);
    stall      = ~rst & ~bus.ex_redirect & (lu_hazard | mdu_hazard);
  end

  always_comb begin
    ctrl_d = '0;
    if (!rst && !bus.ex_redirect && !stall && id_live) ctrl_d = dec;
    // HI/LO busy window restarts only when a mult/div actually enters EX
    mdu_cnt_d = mdu_cnt_q;
    if (ctrl_d.mdu_op != 3'd0 && ctrl_d.mdu_op <= 3'd4) mdu_cnt_d = 8'(MDU_LAT);
    else if (mdu_cnt_q != 8'd0)                         mdu_cnt_d = mdu_cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      mdu_cnt_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign bus.stall_id     = stall;
  assign bus.flush_id     = bus.ex_redirect;
  assign bus.ex_valid     = ctrl_q.valid;
  assign bus.ex_reg_write = ctrl_q.reg_write;
  assign bus.ex_wreg      = ctrl_q.wreg;
  assign bus.ex_mem_read  = ctrl_q.mem_read;
  assign bus.ex_mem_write = ctrl_q.mem_write;
  assign bus.ex_memto_reg = ctrl_q.memto_reg;
  assign bus.ex_mem_size  = ctrl_q.mem_size;
  assign bus.ex_mem_uns   = ctrl_q.mem_uns;
  assign bus.ex_alu_src   = ctrl_q.alu_src;
  assign bus.ex_ext_op    = ctrl_q.ext_op;
  assign bus.ex_alu_op    = ALUOP_W'(ctrl_q.alu_op);
  assign bus.ex_shamt_var = ctrl_q.shamt_var;
  assign bus.ex_shift_op  = ctrl_q.shift_op;
  assign bus.ex_br_op     = ctrl_q.br_op;
  assign bus.ex_jump      = ctrl_q.jump;
  assign bus.ex_jump_reg  = ctrl_q.jump_reg;
  assign bus.ex_call      = ctrl_q.call;
  assign bus.ex_mdu_op    = ctrl_q.mdu_op;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: per-scenario stimulus tables, expected ID/EX bundles queued
// when an instruction is presented and popped after the edge that registers it.
module tb_id_ex_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] wreg;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic [1:0] mem_size;
    logic       mem_uns;
    logic       alu_src;
    logic       ext_op;
    logic [3:0] alu_op;
    logic       shamt_var;
    logic [1:0] shift_op;
    logic [1:0] br_op;
    logic       jump;
    logic       jump_reg;
    logic       call;
    logic [2:0] mdu_op;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        vld;
    logic        redir;
    logic        rs;
    logic        stall;
    exp_t        e;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  id_ex_ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(4)) bus ();

  id_ex_ctrl_pipe #(.REG_AW(5), .ALUOP_W(4), .MDU_LAT(8), .LU_STALL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex_now();
    exp_t g;
    g = '{bus.ex_valid, bus.ex_reg_write, bus.ex_wreg, bus.ex_mem_read, bus.ex_mem_write,
          bus.ex_memto_reg, bus.ex_mem_size, bus.ex_mem_uns, bus.ex_alu_src, bus.ex_ext_op,
          bus.ex_alu_op, bus.ex_shamt_var, bus.ex_shift_op, bus.ex_br_op, bus.ex_jump,
          bus.ex_jump_reg, bus.ex_call, bus.ex_mdu_op};
    return g;
  endfunction

  function automatic step_t st(logic [31:0] ins, logic vld, logic redir, logic r, logic stall, exp_t e);
    step_t s;
    s.ins = ins; s.vld = vld; s.redir = redir; s.rs = r; s.stall = stall; s.e = e;
    return s;
  endfunction

  // Hand-written expected bundles for the instructions used below
  exp_t b0, e_add3, e_lhu4, e_sb7, e_ori9, e_srav10, e_beq, e_jr, e_jal, e_add0;
  exp_t e_lw5, e_add6, e_sw5, e_lw0, e_add6z, e_mult, e_mflo8;

  task automatic build_expect();
    b0 = '0;
    e_add3   = '0; e_add3.valid = 1; e_add3.reg_write = 1; e_add3.wreg = 3; e_add3.alu_op = 4'b0001;
    e_lhu4   = '0; e_lhu4.valid = 1; e_lhu4.reg_write = 1; e_lhu4.wreg = 4; e_lhu4.mem_read = 1;
    e_lhu4.memto_reg = 1; e_lhu4.mem_size = 2'b01; e_lhu4.mem_uns = 1; e_lhu4.alu_src = 1;
    e_lhu4.ext_op = 1; e_lhu4.alu_op = 4'b0001;
    e_sb7    = '0; e_sb7.valid = 1; e_sb7.wreg = 7; e_sb7.mem_write = 1; e_sb7.mem_size = 2'b00;
    e_sb7.alu_src = 1; e_sb7.ext_op = 1; e_sb7.alu_op = 4'b0001;
    e_ori9   = '0; e_ori9.valid = 1; e_ori9.reg_write = 1; e_ori9.wreg = 9; e_ori9.alu_src = 1;
    e_ori9.alu_op = 4'b0100;
    e_srav10 = '0; e_srav10.valid = 1; e_srav10.reg_write = 1; e_srav10.wreg = 10;
    e_srav10.shamt_var = 1; e_srav10.shift_op = 2'b11;
    e_beq    = '0; e_beq.valid = 1; e_beq.wreg = 2; e_beq.br_op = 2'b01; e_beq.ext_op = 1;
    e_jr     = '0; e_jr.valid = 1; e_jr.jump = 1; e_jr.jump_reg = 1;
    e_jal    = '0; e_jal.valid = 1; e_jal.reg_write = 1; e_jal.wreg = 31; e_jal.jump = 1; e_jal.call = 1;
    e_add0   = '0; e_add0.valid = 1; e_add0.alu_op = 4'b0001;
    e_lw5    = '0; e_lw5.valid = 1; e_lw5.reg_write = 1; e_lw5.wreg = 5; e_lw5.mem_read = 1;
    e_lw5.memto_reg = 1; e_lw5.mem_size = 2'b10; e_lw5.alu_src = 1; e_lw5.ext_op = 1;
    e_lw5.alu_op = 4'b0001;
    e_lw0    = e_lw5; e_lw0.reg_write = 0; e_lw0.wreg = 0;
    e_add6   = '0; e_add6.valid = 1; e_add6.reg_write = 1; e_add6.wreg = 6; e_add6.alu_op = 4'b0001;
    e_add6z  = e_add6;
    e_sw5    = '0; e_sw5.valid = 1; e_sw5.wreg = 5; e_sw5.mem_write = 1; e_sw5.mem_size = 2'b10;
    e_sw5.alu_src = 1; e_sw5.ext_op = 1; e_sw5.alu_op = 4'b0001;
    e_mult   = '0; e_mult.valid = 1; e_mult.mdu_op = 3'd1;
    e_mflo8  = '0; e_mflo8.valid = 1; e_mflo8.reg_write = 1; e_mflo8.wreg = 8; e_mflo8.mdu_op = 3'd6;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h00221820, 1, 0, 1, 0, b0));
    s.push_back(st(32'h00221820, 0, 0, 0, 0, b0));
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL reset stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL reset bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_decode();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h00221820, 1, 0, 0, 0, e_add3));
    s.push_back(st(32'h94240002, 1, 0, 0, 0, e_lhu4));
    s.push_back(st(32'hA0270004, 1, 0, 0, 0, e_sb7));
    s.push_back(st(32'h3429FFFF, 1, 0, 0, 0, e_ori9));
    s.push_back(st(32'h00625007, 1, 0, 0, 0, e_srav10));
    s.push_back(st(32'h10220004, 1, 0, 0, 0, e_beq));
    s.push_back(st(32'h03E00008, 1, 0, 0, 0, e_jr));
    s.push_back(st(32'h0C000040, 1, 0, 0, 0, e_jal));
    s.push_back(st(32'h00220020, 1, 0, 0, 0, e_add0));
    s.push_back(st(32'hFC000000, 1, 0, 0, 0, b0));
    s.push_back(st(32'h00221820, 0, 0, 0, 0, b0));
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL decode stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL decode bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h8C250000, 1, 0, 0, 0, e_lw5));    // lw  $5,0($1)
    s.push_back(st(32'h00A23020, 1, 0, 0, 1, b0));       // add $6,$5,$2 stalls once
    s.push_back(st(32'h00A23020, 1, 0, 0, 0, e_add6));
    s.push_back(st(32'h8C250000, 1, 0, 0, 0, e_lw5));
    s.push_back(st(32'hAC250000, 1, 0, 0, 1, b0));       // sw $5 reads rt
    s.push_back(st(32'hAC250000, 1, 0, 0, 0, e_sw5));
    s.push_back(st(32'h8C200000, 1, 0, 0, 0, e_lw0));    // lw $0: no hazard on $0
    s.push_back(st(32'h00023020, 1, 0, 0, 0, e_add6z));
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL load_use stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL load_use bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mdu_busy();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h00220018, 1, 0, 0, 0, e_mult));
    for (int k = 0; k < 8; k++) s.push_back(st(32'h00004012, 1, 0, 0, 1, b0));
    s.push_back(st(32'h00004012, 1, 0, 0, 0, e_mflo8));
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL mdu_busy stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL mdu_busy bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h8C250000, 1, 0, 0, 0, e_lw5));
    s.push_back(st(32'h00A23020, 1, 1, 0, 0, b0));       // redirect beats load-use stall
    s.push_back(st(32'h00A23020, 1, 0, 0, 0, e_add6));
    s.push_back(st(32'h00220018, 1, 0, 0, 0, e_mult));
    for (int k = 0; k < 8; k++) s.push_back(st(32'h00004012, 1, 1, 0, 0, b0));
    s.push_back(st(32'h00004012, 1, 0, 0, 0, e_mflo8));  // busy window elapsed under redirect
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL redirect stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      n_cmp++;
      if (bus.flush_id !== s[i].redir) begin
        n_bad++; $display("FAIL redirect flush step %0d: got %b want %b", i, bus.flush_id, s[i].redir);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL redirect bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_mdu();
    step_t s[$];
    exp_t  got, exp;
    s.push_back(st(32'h00220018, 1, 0, 0, 0, e_mult));
    s.push_back(st(32'h00004012, 1, 0, 0, 1, b0));        // busy: mflo stalls
    s.push_back(st(32'h00004012, 1, 0, 1, 0, b0));        // rst mid-busy: no stall, bubble
    s.push_back(st(32'h00004012, 1, 0, 0, 0, e_mflo8));   // counter cleared: issues at once
    foreach (s[i]) begin
      rst = s[i].rs; bus.id_instr = s[i].ins; bus.id_valid = s[i].vld; bus.ex_redirect = s[i].redir;
      sb_q.push_back(s[i].e);
      #1;
      n_cmp++;
      if (bus.stall_id !== s[i].stall) begin
        n_bad++; $display("FAIL rst_mid stall step %0d: got %b want %b", i, bus.stall_id, s[i].stall);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = ex_now();
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL rst_mid bundle step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    bus.id_instr    = '0;
    bus.id_valid    = 1'b0;
    bus.ex_redirect = 1'b0;
    build_expect();
    test_reset();
    test_decode();
    test_load_use();
    test_mdu_busy();
    test_redirect();
    test_reset_mid_mdu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
